// File: rtl/cen_gen_multi.sv
// ---------------------------------------------------------------------------
// cen_gen_multi
//
// Multi-channel fractional clock-enable generator. Each channel owns a
// NUM/DEN phase accumulator and emits single-cycle enable pulses in the
// clk_sys domain, so non-integer division ratios are exact on average
// (num pulses per den counting cycles, spacing floor/ceil of den/num).
//
// Ports:
//   clk_sys     sole clock of the block
//   reset_n     asynchronous, active-low reset; loads DEF_NUM / DEF_DEN
//   pause       freeze: accumulators hold, all enables forced low
//   sync_clr    one-cycle pulse, clears every accumulator (phase realign)
//   cfg_wr      one-cycle write strobe for the ratio registers
//   cfg_ch      channel index of the write (out-of-range index ignored)
//   cfg_num     new numerator
//   cfg_den     new denominator
//   cen         per-channel registered enable pulses
//   cen_active  per-channel flag, 1 when num != 0 and den != 0
//   cen_lvl     (only with CEN_GEN_LEVEL_OUT_EN) per-channel level that
//               toggles on every edge where cen is 1
//
// Configuration write semantics: the config port has no ready/backpressure.
// cfg_wr is a strobe sampled on every clk_sys edge; when high, the addressed
// channel takes cfg_num/cfg_den on that edge unconditionally, even if
// sync_clr or pause is also high, and restarts with a cleared accumulator.
//
// Optional feature macro: CEN_GEN_LEVEL_OUT_EN adds the cen_lvl output.
// ---------------------------------------------------------------------------
module cen_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 16,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM = {4{16'd1}},
  parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN = {4{16'd10}},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pause,
  input  logic              sync_clr,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic [NUM_CH-1:0] cen,
  output logic [NUM_CH-1:0] cen_active
`ifdef CEN_GEN_LEVEL_OUT_EN
  ,
  output logic [NUM_CH-1:0] cen_lvl
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    logic [ACC_W-1:0] num_r;
    logic [ACC_W-1:0] den_r;
    logic [ACC_W-1:0] acc_r;
    logic             cen_q;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_wrap;
    logic             wr_sel;
    logic             idle;
    logic             hit;
    logic             sat;

    assign wr_sel = cfg_wr && (cfg_ch == IDX);
    assign idle   = (num_r == '0) || (den_r == '0);

    // acc < den and num < 2^ACC_W, so the sum fits in ACC_W+1 bits.
    assign sum = {1'b0, acc_r} + {1'b0, num_r};
    assign hit = (sum >= {1'b0, den_r});

    // When hit, sum - den < den < 2^ACC_W, so the low bits of the
    // modular difference are the exact remainder.
    assign acc_wrap = sum[ACC_W-1:0] - den_r;

    // num >= den: pulse every cycle; the excess has no meaning for the
    // output, so the accumulator is parked at zero which keeps acc < den.
    assign sat = (num_r >= den_r);

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        num_r <= DEF_NUM[i*ACC_W +: ACC_W];
        den_r <= DEF_DEN[i*ACC_W +: ACC_W];
        acc_r <= '0;
        cen_q <= 1'b0;
      end else begin
        // The register load is independent of sync_clr: a write in the
        // same cycle as a global clear must not be lost.
        if (wr_sel) begin
          num_r <= cfg_num;
          den_r <= cfg_den;
        end

        if (sync_clr || wr_sel) begin
          acc_r <= '0;
          cen_q <= 1'b0;
        end else if (pause) begin
          cen_q <= 1'b0;
        end else if (idle) begin
          acc_r <= '0;
          cen_q <= 1'b0;
        end else if (sat) begin
          acc_r <= '0;
          cen_q <= 1'b1;
        end else if (hit) begin
          acc_r <= acc_wrap;
          cen_q <= 1'b1;
        end else begin
          acc_r <= sum[ACC_W-1:0];
          cen_q <= 1'b0;
        end
      end
    end

    assign cen[i]        = cen_q;
    assign cen_active[i] = !idle;

`ifdef CEN_GEN_LEVEL_OUT_EN
    logic lvl_q;

    // Divided level: toggles once per enable pulse, frozen by pause.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        lvl_q <= 1'b0;
      end else if (sync_clr) begin
        lvl_q <= 1'b0;
      end else if (!pause && cen_q) begin
        lvl_q <= ~lvl_q;
      end
    end

    assign cen_lvl[i] = lvl_q;
`else
    // Level output not built in this configuration.
`endif

    // Accumulator invariant: a zero denominator keeps acc at zero,
    // otherwise acc is always strictly below den.
    a_acc_range : assert property (@(posedge clk_sys) disable iff (!reset_n)
      (den_r == '0) ? (acc_r == '0) : (acc_r < den_r));
  end

endmodule

// File: tb/tb_cen_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_cen_gen_multi
//
// Bench for cen_gen_multi (default parameters). The reference model tracks,
// per channel, the number of counting edges t since the last restart; for
// num < den a pulse is expected at edge t exactly when floor(t*num/den)
// increments, for num >= den on every counting edge. Expected outputs are
// queued at each edge and popped when the DUT is sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_cen_gen_multi;
  localparam int NUM_CH = 4;
  localparam int ACC_W  = 16;
  localparam int EXP_W  = 12;

  // ---------------- clock / reset / DUT ----------------
  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              pause;
  logic              sync_clr;
  logic              cfg_wr;
  logic [1:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_num;
  logic [ACC_W-1:0]  cfg_den;
  logic [NUM_CH-1:0] cen;
  logic [NUM_CH-1:0] cen_active;
`ifdef CEN_GEN_LEVEL_OUT_EN
  logic [NUM_CH-1:0] cen_lvl;
`endif

  always #5 clk_sys = ~clk_sys;

  cen_gen_multi dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .pause      (pause),
    .sync_clr   (sync_clr),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_num    (cfg_num),
    .cfg_den    (cfg_den),
    .cen        (cen),
    .cen_active (cen_active)
`ifdef CEN_GEN_LEVEL_OUT_EN
    ,
    .cen_lvl    (cen_lvl)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint unsigned   m_num [NUM_CH];
  longint unsigned   m_den [NUM_CH];
  longint unsigned   m_t   [NUM_CH];
  logic [NUM_CH-1:0] m_cen;
  logic [NUM_CH-1:0] m_lvl;

  function automatic logic [NUM_CH-1:0] model_active();
    logic [NUM_CH-1:0] a;
    for (int i = 0; i < NUM_CH; i++) a[i] = (m_num[i] != 0) && (m_den[i] != 0);
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_num[i] = 1;
      m_den[i] = 10;
      m_t[i]   = 0;
    end
    m_cen = '0;
    m_lvl = '0;
    exp_q.delete();
  endtask

  // Applies the inputs seen on one clk_sys edge.
  task automatic model_edge();
    logic [NUM_CH-1:0] prev_cen;
    bit sel;
    prev_cen = m_cen;
    for (int i = 0; i < NUM_CH; i++) begin
      sel = cfg_wr && (int'(cfg_ch) == i);
      if (sync_clr || sel) begin
        if (sel) begin
          m_num[i] = cfg_num;
          m_den[i] = cfg_den;
        end
        m_t[i]   = 0;
        m_cen[i] = 1'b0;
      end else if (pause) begin
        m_cen[i] = 1'b0;
      end else if (m_num[i] == 0 || m_den[i] == 0) begin
        m_t[i]   = 0;
        m_cen[i] = 1'b0;
      end else begin
        m_t[i]++;
        if (m_num[i] >= m_den[i])
          m_cen[i] = 1'b1;
        else
          m_cen[i] = ((m_t[i] * m_num[i]) / m_den[i]) !=
                     (((m_t[i] - 1) * m_num[i]) / m_den[i]);
      end
      if (sync_clr)
        m_lvl[i] = 1'b0;
      else if (!pause && prev_cen[i])
        m_lvl[i] = ~m_lvl[i];
    end
    exp_q.push_back({m_lvl, model_active(), m_cen});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [EXP_W-1:0] e;
    @(posedge clk_sys);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("cen", 32'(cen), 32'(e[3:0]));
    check("cen_active", 32'(cen_active), 32'(e[7:4]));
`ifdef CEN_GEN_LEVEL_OUT_EN
    check("cen_lvl", 32'(cen_lvl), 32'(e[11:8]));
`endif
  endtask

  task automatic write_cfg(input int ch, input int num, input int den);
    cfg_wr  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_num = ACC_W'(num);
    cfg_den = ACC_W'(den);
    cycle();
    cfg_wr  = 1'b0;
  endtask

  // Counting edges until cen[ch] is seen high; max_cyc+1 means timeout.
  task automatic wait_pulse(input int ch, input int max_cyc, output int n);
    n = 0;
    for (int k = 0; k < max_cyc; k++) begin
      cycle();
      n++;
      if (cen[ch]) return;
    end
    n = max_cyc + 1;
  endtask

  task automatic count_pulses(input int ch, input int ncyc, output int cnt);
    cnt = 0;
    for (int k = 0; k < ncyc; k++) begin
      cycle();
      if (cen[ch]) cnt++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int cnt;
    int last;
    int gmin;
    int gmax;

    reset_n  = 1'b0;
    pause    = 1'b0;
    sync_clr = 1'b0;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_num  = '0;
    cfg_den  = '0;
    model_reset();
    #12;
    check("rst_cen", 32'(cen), 32'(m_cen));
    check("rst_active", 32'(cen_active), 32'(model_active()));
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Defaults 1/10: ten pulses in 100 cycles, on multiples of 10.
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      cycle();
      if (cen[0]) begin
        cnt++;
        check("s1_pulse_pos", 32'(k % 10), 32'd0);
      end
    end
    check("s1_pulses", 32'(cnt), 32'd10);

    // ch1 = 2/25: first pulse at edge 13, 8 pulses in 100, gaps 12/13.
    write_cfg(1, 2, 25);
    wait_pulse(1, 40, n);
    check("s2_first", 32'(n), 32'd13);
    cnt  = 1;
    last = n;
    gmin = 1000;
    gmax = 0;
    for (int k = n + 1; k <= 100; k++) begin
      cycle();
      if (cen[1]) begin
        cnt++;
        if (k - last < gmin) gmin = k - last;
        if (k - last > gmax) gmax = k - last;
        last = k;
      end
    end
    check("s2_pulses", 32'(cnt), 32'd8);
    check("s2_gap_min", 32'(gmin), 32'd12);
    check("s2_gap_max", 32'(gmax), 32'd13);

    // ch2 = 5/3: saturated, high every cycle from the first edge.
    write_cfg(2, 5, 3);
    count_pulses(2, 20, cnt);
    check("s3_sat", 32'(cnt), 32'd20);

    // ch3 idle via den=0, then via num=0.
    write_cfg(3, 3, 0);
    count_pulses(3, 30, cnt);
    check("s4_den0", 32'(cnt), 32'd0);
    check("s4_active", 32'(cen_active[3]), 32'd0);
    write_cfg(3, 0, 7);
    count_pulses(3, 30, cnt);
    check("s4_num0", 32'(cnt), 32'd0);

    // Pause with ch0 at acc=4, then release: pulse 6 edges later.
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    repeat (4) cycle();
    pause = 1'b1;
    count_pulses(0, 7, cnt);
    check("s5_paused", 32'(cnt), 32'd0);
    pause = 1'b0;
    wait_pulse(0, 20, n);
    check("s5_resume", 32'(n), 32'd6);
    repeat (3) cycle();
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    wait_pulse(0, 20, n);
    check("s5_sync", 32'(n), 32'd10);

    // sync_clr together with a ch0 write of 1/4.
    sync_clr = 1'b1;
    write_cfg(0, 1, 4);
    sync_clr = 1'b0;
    wait_pulse(0, 10, n);
    check("s6_first", 32'(n), 32'd4);
    wait_pulse(0, 10, n);
    check("s6_second", 32'(n), 32'd4);

    // Reset while cen[0] is high: asynchronous clear, defaults back.
    reset_n = 1'b0;
    model_reset();
    #1;
    check("s6_async_cen", 32'(cen), 32'(m_cen));
    check("s6_async_active", 32'(cen_active), 32'(model_active()));
    @(negedge clk_sys);
    reset_n = 1'b1;
    wait_pulse(0, 20, n);
    check("s6_defaults", 32'(n), 32'd10);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      sync_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      cfg_wr = ($urandom_range(0, 24) == 0);
      cfg_ch = 2'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 7) == 0) begin
        cfg_num = ACC_W'($urandom_range(32768, 65535));
        cfg_den = ACC_W'($urandom_range(1, 65535));
      end else begin
        cfg_num = ACC_W'($urandom_range(0, 40));
        cfg_den = ACC_W'($urandom_range(0, 60));
      end
      cycle();
    end
    sync_clr = 1'b0;
    pause    = 1'b0;
    cfg_wr   = 1'b0;
    repeat (5) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
